// File: rtl/vga_timing_gen_if.sv
// Raster output bundle of the VGA timing generator.
// The generator drives through master; the renderer/DAC side uses slave.
interface vga_timing_gen_if #(
  parameter int COORD_W = 11
) ();
  logic               enable;
  logic [COORD_W-1:0] x_coord;
  logic [COORD_W-1:0] y_coord;
  logic               line_start;
  logic               frame_start;
  logic               hsync;
  logic               vsync;
  logic               display_en;
  logic [15:0]        frame_count;

  modport master (
    input  enable,
    output x_coord, y_coord,
    output line_start, frame_start,
    output hsync, vsync, display_en,
    output frame_count
  );

  modport slave (
    output enable,
    input  x_coord, y_coord,
    input  line_start, frame_start,
    input  hsync, vsync, display_en,
    input  frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/DVI raster timing generator; coordinates lead syncs by PIPE_DELAY.
// Optional frame counter is built when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int PIPE_DELAY = 2,
  parameter int COORD_W    = 11
) (
  input logic clk,
  input logic reset_lock,
  vga_timing_gen_if.master bus
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [COORD_W-1:0] H_SYNC_C  = COORD_W'(H_SYNC);
  localparam logic [COORD_W-1:0] H_BEG_C   = COORD_W'(H_SYNC + H_BP);
  localparam logic [COORD_W-1:0] H_END_C   = COORD_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [COORD_W-1:0] H_LAST_C  = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_SYNC_C  = COORD_W'(V_SYNC);
  localparam logic [COORD_W-1:0] V_BEG_C   = COORD_W'(V_SYNC + V_BP);
  localparam logic [COORD_W-1:0] V_END_C   = COORD_W'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [COORD_W-1:0] V_LAST_C  = COORD_W'(V_TOTAL - 1);

  logic [COORD_W-1:0] hcount;
  logic [COORD_W-1:0] vcount;
  logic               h_last;
  logic               v_last;
  logic               de_now;

  logic               raw_hs;
  logic               raw_vs;
  logic               raw_de;
  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  logic               ls_q;
  logic               fs_q;

  assign h_last = (hcount == H_LAST_C);
  assign v_last = (vcount == V_LAST_C);
  assign de_now = (hcount >= H_BEG_C) && (hcount < H_END_C) &&
                  (vcount >= V_BEG_C) && (vcount < V_END_C);

  // Raster counters: hcount every enabled cycle, vcount on the line wrap.
  always_ff @(posedge clk or negedge reset_lock) begin
    if (!reset_lock) begin
      hcount <= '0;
      vcount <= '0;
    end else if (bus.enable) begin
      hcount <= h_last ? '0 : hcount + 1'b1;
      if (h_last) vcount <= v_last ? '0 : vcount + 1'b1;
    end
  end

  // Stage 1: decode the counters into raw levels, coordinates and pulses.
  always_ff @(posedge clk or negedge reset_lock) begin
    if (!reset_lock) begin
      raw_hs <= ~HS_POL;
      raw_vs <= ~VS_POL;
      raw_de <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else if (bus.enable) begin
      raw_hs <= (hcount < H_SYNC_C) ? HS_POL : ~HS_POL;
      raw_vs <= (vcount < V_SYNC_C) ? VS_POL : ~VS_POL;
      raw_de <= de_now;
      x_q    <= de_now ? hcount - H_BEG_C : '0;
      y_q    <= de_now ? vcount - V_BEG_C : '0;
      ls_q   <= (hcount == '0);
      fs_q   <= (hcount == '0) && (vcount == '0);
    end
  end

  assign bus.x_coord     = x_q;
  assign bus.y_coord     = y_q;
  assign bus.line_start  = ls_q;
  assign bus.frame_start = fs_q;

  generate
    if (PIPE_DELAY == 0) begin : g_nodly
      assign bus.hsync      = raw_hs;
      assign bus.vsync      = raw_vs;
      assign bus.display_en = raw_de;
    end else begin : g_dly
      logic [PIPE_DELAY-1:0] hs_d;
      logic [PIPE_DELAY-1:0] vs_d;
      logic [PIPE_DELAY-1:0] de_d;

      // Delay line realigning syncs with a renderer of PIPE_DELAY latency.
      always_ff @(posedge clk or negedge reset_lock) begin
        if (!reset_lock) begin
          hs_d <= {PIPE_DELAY{~HS_POL}};
          vs_d <= {PIPE_DELAY{~VS_POL}};
          de_d <= '0;
        end else if (bus.enable) begin
          hs_d[0] <= raw_hs;
          vs_d[0] <= raw_vs;
          de_d[0] <= raw_de;
          for (int i = 1; i < PIPE_DELAY; i++) begin
            hs_d[i] <= hs_d[i-1];
            vs_d[i] <= vs_d[i-1];
            de_d[i] <= de_d[i-1];
          end
        end
      end

      assign bus.hsync      = hs_d[PIPE_DELAY-1];
      assign bus.vsync      = vs_d[PIPE_DELAY-1];
      assign bus.display_en = de_d[PIPE_DELAY-1];
    end
  endgenerate

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fcnt;

  // Completed frames, bumped on the edge where both counters wrap.
  always_ff @(posedge clk or negedge reset_lock) begin
    if (!reset_lock) begin
      fcnt <= 16'h0000;
    end else if (bus.enable && h_last && v_last) begin
      fcnt <= fcnt + 16'h0001;
    end
  end

  assign bus.frame_count = fcnt;
`else
  assign bus.frame_count = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: reset, widths, alignment, wrap, freeze.
// Sample n is taken at the negedge after enabled edge n (counter value n-1).
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset_lock = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   n = 0;

`ifdef VGA_TIMING_FRAME_CNT_EN
  localparam int FC2 = 2;
  localparam int FC3 = 3;
`else
  localparam int FC2 = 0;
  localparam int FC3 = 0;
`endif

  vga_timing_gen_if #(.COORD_W(11)) b0 ();
  vga_timing_gen_if #(.COORD_W(11)) b2 ();
  vga_timing_gen_if #(.COORD_W(11)) b5 ();
  vga_timing_gen_if #(.COORD_W(11)) bs ();

  vga_timing_gen #(.PIPE_DELAY(0)) d0 (
    .clk(clk), .reset_lock(reset_lock), .bus(b0)
  );
  vga_timing_gen #(.PIPE_DELAY(2)) d2 (
    .clk(clk), .reset_lock(reset_lock), .bus(b2)
  );
  vga_timing_gen #(.PIPE_DELAY(5)) d5 (
    .clk(clk), .reset_lock(reset_lock), .bus(b5)
  );
  // Small raster: 15 x 8 = 120 cycles/frame, inverted polarities.
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DELAY(1)
  ) ds (
    .clk(clk), .reset_lock(reset_lock), .bus(bs)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
    n++;
  endtask

  task automatic test_reset;
    b0.enable = 1'b1;
    b2.enable = 1'b1;
    b5.enable = 1'b1;
    bs.enable = 1'b1;
    reset_lock = 1'b0;
    repeat (3) tick();
    tests++;
    if (b0.hsync !== 1'b1 || b0.vsync !== 1'b1) begin
      fails++;
      $display("FAIL rst_sync got hs=%b vs=%b want 1 1",
               b0.hsync, b0.vsync);
    end
    tests++;
    if (b0.display_en !== 1'b0 || b0.x_coord !== 11'd0 ||
        b0.y_coord !== 11'd0) begin
      fails++;
      $display("FAIL rst_de_xy got de=%b x=%0d y=%0d want 0 0 0",
               b0.display_en, b0.x_coord, b0.y_coord);
    end
    tests++;
    if (b0.line_start !== 1'b0 || b0.frame_start !== 1'b0 ||
        b0.frame_count !== 16'd0) begin
      fails++;
      $display("FAIL rst_pulses got ls=%b fs=%b fc=%0d want 0 0 0",
               b0.line_start, b0.frame_start, b0.frame_count);
    end
    tests++;
    if (bs.hsync !== 1'b0 || bs.vsync !== 1'b0 ||
        b5.hsync !== 1'b1) begin
      fails++;
      $display("FAIL rst_pol got s_hs=%b s_vs=%b d5_hs=%b want 0 0 1",
               bs.hsync, bs.vsync, b5.hsync);
    end
    reset_lock = 1'b1;
    n = 0;
    repeat (20) tick();
    tests++;
    if (b0.hsync !== 1'b0 || b2.hsync !== 1'b0) begin
      fails++;
      $display("FAIL pre_midrst got hs0=%b hs2=%b want 0 0",
               b0.hsync, b2.hsync);
    end
    #2 reset_lock = 1'b0;
    #1;
    tests++;
    if (b0.hsync !== 1'b1 || b2.hsync !== 1'b1 ||
        b0.vsync !== 1'b1) begin
      fails++;
      $display("FAIL midrst_async got hs0=%b hs2=%b vs0=%b want 1 1 1",
               b0.hsync, b2.hsync, b0.vsync);
    end
    tick();
    reset_lock = 1'b1;
    n = 0;
  endtask

  task automatic test_restart;
    tick();
    tests++;
    if (b0.frame_start !== 1'b1 || b0.line_start !== 1'b1 ||
        b0.hsync !== 1'b0) begin
      fails++;
      $display("FAIL restart_s1 got fs=%b ls=%b hs=%b want 1 1 0",
               b0.frame_start, b0.line_start, b0.hsync);
    end
    tick();
    tests++;
    if (b0.frame_start !== 1'b0 || b0.line_start !== 1'b0 ||
        bs.hsync !== 1'b1) begin
      fails++;
      $display("FAIL restart_s2 got fs=%b ls=%b s_hs=%b want 0 0 1",
               b0.frame_start, b0.line_start, bs.hsync);
    end
  endtask

  task automatic test_small_raster;
    int fs_cnt = 1;
    int hs_cnt = 1;
    int vs_cnt = 1;
    int de_cnt = 0;
    int xmax = 0;
    int ymax = 0;
    while (n < 360) begin
      tick();
      if (bs.frame_start) fs_cnt++;
      if (n <= 121) begin
        if (bs.hsync) hs_cnt++;
        if (bs.vsync) vs_cnt++;
        if (bs.display_en) de_cnt++;
        if (int'(bs.x_coord) > xmax) xmax = int'(bs.x_coord);
        if (int'(bs.y_coord) > ymax) ymax = int'(bs.y_coord);
      end
      if (n == 52 || n == 97) begin
        tests++;
        if (bs.x_coord !== 11'd1 ||
            bs.y_coord !== ((n == 52) ? 11'd0 : 11'd3)) begin
          fails++;
          $display("FAIL small_xy n=%0d got x=%0d y=%0d",
                   n, bs.x_coord, bs.y_coord);
        end
      end
      if (n == 359) begin
        tests++;
        if (bs.frame_count !== 16'(FC2)) begin
          fails++;
          $display("FAIL fc_before got %0d want %0d",
                   bs.frame_count, FC2);
        end
      end
    end
    tests++;
    if (bs.frame_count !== 16'(FC3)) begin
      fails++;
      $display("FAIL fc_three got %0d want %0d", bs.frame_count, FC3);
    end
    tests++;
    if (fs_cnt != 3) begin
      fails++;
      $display("FAIL small_fs_cnt got %0d want 3", fs_cnt);
    end
    tests++;
    if (hs_cnt != 24 || vs_cnt != 15 || de_cnt != 32) begin
      fails++;
      $display("FAIL small_widths got hs=%0d vs=%0d de=%0d want 24 15 32",
               hs_cnt, vs_cnt, de_cnt);
    end
    tests++;
    if (xmax != 7 || ymax != 3) begin
      fails++;
      $display("FAIL small_xymax got x=%0d y=%0d want 7 3", xmax, ymax);
    end
  endtask

  task automatic test_hsync_width;
    int hs_low = 0;
    int ls_cnt = 0;
    int de_cnt = 0;
    while (n < 1600) begin
      tick();
      if (n > 800) begin
        if (!b0.hsync) hs_low++;
        if (b0.line_start) ls_cnt++;
        if (b0.display_en) de_cnt++;
      end
    end
    tests++;
    if (hs_low != 96 || ls_cnt != 1 || de_cnt != 0) begin
      fails++;
      $display("FAIL line1_widths got hs=%0d ls=%0d de=%0d want 96 1 0",
               hs_low, ls_cnt, de_cnt);
    end
    tests++;
    if (b0.vsync !== 1'b0) begin
      fails++;
      $display("FAIL vs_line1 got %b want 0", b0.vsync);
    end
    tick();
    tests++;
    if (b0.vsync !== 1'b1) begin
      fails++;
      $display("FAIL vs_line2 got %b want 1", b0.vsync);
    end
  endtask

  task automatic test_alignment;
    int rise0 = -1;
    int rise2 = -1;
    int rise5 = -1;
    int x1_0 = -1;
    int x1_5 = -1;
    int de34 = 0;
    int de35 = 0;
    int hs35 = 0;
    while (n < 28800) begin
      tick();
      if (b0.display_en && rise0 < 0) rise0 = n;
      if (b2.display_en && rise2 < 0) rise2 = n;
      if (b5.display_en && rise5 < 0) rise5 = n;
      if (b0.x_coord == 11'd1 && x1_0 < 0) x1_0 = n;
      if (b5.x_coord == 11'd1 && x1_5 < 0) x1_5 = n;
      if (n > 27200 && n <= 28000 && b0.display_en) de34++;
      if (n > 28000) begin
        if (b0.display_en) de35++;
        if (!b0.hsync) hs35++;
      end
      if (n == 28146) begin
        tests++;
        if (b0.y_coord !== 11'd0 || b2.y_coord !== 11'd0) begin
          fails++;
          $display("FAIL first_y got y0=%0d y2=%0d want 0 0",
                   b0.y_coord, b2.y_coord);
        end
      end
      if (n == 28784 || n == 28785) begin
        tests++;
        if (b0.x_coord !== ((n == 28784) ? 11'd639 : 11'd0)) begin
          fails++;
          $display("FAIL x_end n=%0d got %0d", n, b0.x_coord);
        end
      end
    end
    tests++;
    if (x1_0 != 28146 || x1_5 != 28146) begin
      fails++;
      $display("FAIL x_start got %0d %0d want 28146", x1_0, x1_5);
    end
    tests++;
    if (rise0 != 28145 || rise2 != 28147 || rise5 != 28150) begin
      fails++;
      $display("FAIL de_rise got %0d %0d %0d want 28145 28147 28150",
               rise0, rise2, rise5);
    end
    tests++;
    if (de34 != 0 || de35 != 640 || hs35 != 96) begin
      fails++;
      $display("FAIL line35 got de34=%0d de35=%0d hs=%0d want 0 640 96",
               de34, de35, hs35);
    end
  endtask

  task automatic test_freeze;
    logic [10:0] x_h;
    logic        hs_h;
    logic        de_h;
    int          held_bad = 0;
    int          ls0 = -1;
    int          ls2 = -1;
    int          hs_low = 0;
    int          de_cnt = 0;
    while (n < 29000) tick();
    x_h  = b2.x_coord;
    hs_h = b2.hsync;
    de_h = b2.display_en;
    tests++;
    if (x_h !== 11'd55 || hs_h !== 1'b1 || de_h !== 1'b1) begin
      fails++;
      $display("FAIL pre_freeze got x=%0d hs=%b de=%b want 55 1 1",
               x_h, hs_h, de_h);
    end
    b2.enable = 1'b0;
    repeat (10) begin
      tick();
      if (b2.x_coord !== x_h || b2.hsync !== hs_h ||
          b2.display_en !== de_h) held_bad++;
    end
    b2.enable = 1'b1;
    tests++;
    if (held_bad != 0) begin
      fails++;
      $display("FAIL freeze_hold got %0d changed samples want 0", held_bad);
    end
    tick();
    tests++;
    if (b2.x_coord !== 11'd56) begin
      fails++;
      $display("FAIL resume_x got %0d want 56", b2.x_coord);
    end
    while (n < 30410) begin
      tick();
      if (b0.line_start && ls0 < 0) ls0 = n;
      if (b2.line_start && ls2 < 0) ls2 = n;
      if (n >= 29611) begin
        if (!b2.hsync) hs_low++;
        if (b2.display_en) de_cnt++;
      end
    end
    tests++;
    if (ls0 != 29601 || ls2 != 29611) begin
      fails++;
      $display("FAIL freeze_late got ls0=%0d ls2=%0d want 29601 29611",
               ls0, ls2);
    end
    tests++;
    if (hs_low != 96 || de_cnt != 640) begin
      fails++;
      $display("FAIL freeze_widths got hs=%0d de=%0d want 96 640",
               hs_low, de_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_restart();
    test_small_raster();
    test_hsync_width();
    test_alignment();
    test_freeze();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA/DVI raster timing generator, the successor to the fixed 640x480 timing block. It generates the full raster from per-field parameters and selectable sync polarities. Its `x_coord`/`y_coord` request outputs run PIPE_DELAY cycles ahead of the sync/blank outputs, so a renderer with PIPE_DELAY cycles of latency lines up with the syncs without external delay lines. It sits between the PLL-clocked domain and the pixel renderer / DAC interface.

## Interface

- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clk cycles)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- PIPE_DELAY, 2, extra cycles on hsync/vsync/display_en relative to coordinates (0..15)
- COORD_W, 11, width of counters and coordinates; must hold H_TOTAL-1 and V_TOTAL-1
- clk  in  1  pixel clock
- reset_lock  in  1  reset, asynchronous, active-low (PLL lock AND board reset)
- enable  in  1  1 = advance raster; 0 = freeze every register
- x_coord  out  COORD_W  active-area column of current request, 0 outside active area
- y_coord  out  COORD_W  active-area row of current request, 0 outside active area
- line_start  out  1  one-cycle pulse, coordinate-aligned, at hcount==0
- frame_start  out  1  one-cycle pulse, coordinate-aligned, at hcount==0 and vcount==0
- hsync  out  1  horizontal sync, polarity HS_POL, delayed PIPE_DELAY
- vsync  out  1  vertical sync, polarity VS_POL, delayed PIPE_DELAY
- display_en  out  1  active-area flag, delayed PIPE_DELAY
- frame_count  out  16  completed-frame counter (see Configuration)

## Operation

- H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL likewise. Defaults give 800x525.
- Line order: sync [0,H_SYNC), back porch, active [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE), front porch. Vertical order is identical in lines.
- hcount increments each enabled cycle and wraps H_TOTAL-1 -> 0.
- vcount increments only on the hcount wrap cycle and wraps V_TOTAL-1 -> 0.
- Stage 1 (registered from the counters):
  - raw_hs, raw_vs, raw_de
  - x_coord = hcount-(H_SYNC+H_BP) when active, else 0; y_coord likewise
  - line_start, frame_start
- Stage 2..: raw_hs/raw_vs/raw_de pass through a PIPE_DELAY-deep shift register. PIPE_DELAY=0 outputs the stage-1 values directly.
- enable=0 holds the counters, stage 1, the delay line and frame_count. Pulses therefore stay high if frozen while high; consumers qualify them with enable.
- No internal synchroniser; reset_lock is deasserted synchronously upstream.

## Timing

- Reset (reset_lock=0), asynchronous:
  - counters = 0
  - x_coord = y_coord = 0
  - line_start = frame_start = 0, display_en = 0
  - hsync = ~HS_POL, vsync = ~VS_POL
  - frame_count = 0
  - delay-line stages load these inactive levels
- After release, enabled clock edge k captures counter value k-1 into stage 1.
- Latency:
  - coordinates and pulses: 1 cycle after the counter value
  - hsync/vsync/display_en: 1+PIPE_DELAY cycles after the counter value
- Counter boundaries:
  - At hcount=H_TOTAL-1 and vcount=V_TOTAL-1, both counters wrap on the same edge.
  - frame_count increments on that same edge and wraps 0xFFFF -> 0.
- Reset mid-frame: all outputs go to reset values immediately. Restart is at hcount=vcount=0, so the first stage-1 value after release is a frame_start.

## Configuration

- VGA_TIMING_FRAME_CNT_EN defined: the 16-bit frame_count register is built as above.
- Not defined: frame_count is tied to 16'h0000 and no register is inferred.

## Test plan

- Reset: hold reset_lock=0 with clk running -> hsync=1, vsync=1, display_en=0, x=y=0, frame_count=0 (defaults). Pulse reset mid-line -> same values within the same cycle.
- Defaults, PIPE_DELAY=0, enable=1 -> hsync low exactly 96 cycles per 800; vsync low exactly 2 lines (1600 cycles) per 525 lines.
- Defaults -> display_en high 640 cycles per line on lines 35..514 only; x_coord runs 0..639; y_coord runs 0..479.
- Alignment -> with PIPE_DELAY=2 the first display_en rise is exactly 2 cycles after x_coord first reads 0 with y_coord=0; repeat with PIPE_DELAY=0, then 5.
- Wrap -> frame_start pulses once per 420000 cycles; with the macro defined, frame_count reads 3 after three frames. Without the macro, frame_count stays 0.
- Freeze: drop enable for 10 cycles mid-active -> x_coord, hsync and display_en are held; the line completes 10 cycles late and all widths are unchanged. Run with HS_POL=VS_POL=1 -> sync levels are inverted.
